// File: rtl/esm_pkg.sv
// Shared ESM types and constants used by the dwell status report path.
// The report framing (magic / seq / module / type) matches what esm_config
// parses on the inbound side, so both directions share one vocabulary.
package esm_pkg;

  // Report framing constants
  localparam logic [31:0] esm_report_magic_num                = 32'h4553_4D52;
  localparam logic [7:0]  esm_module_id_dwell_controller      = 8'h03;
  localparam logic [7:0]  esm_report_message_type_dwell_stats = 8'h21;
  localparam int          esm_dwell_report_num_words          = 10;

  // Dwell metadata as driven by esm_dwell_controller
  typedef struct packed {
    logic [15:0] tag;
    logic [15:0] frequency;
    logic [31:0] duration;
    logic [7:0]  gain;
    logic [7:0]  fast_lock_profile;
  } esm_dwell_metadata_t;

  // Payload captured at the end of a dwell: everything carried in beats w3..w9
  typedef struct packed {
    logic [31:0] dwell_sequence_num;
    logic [15:0] frequency;
    logic [15:0] tag;
    logic [31:0] duration;
    logic [31:0] active_cycles;
    logic [63:0] start_timestamp;
    logic [7:0]  gain;
    logic [7:0]  fast_lock_profile;
    logic [15:0] drop_count;
  } esm_dwell_report_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } esm_report_state_t;

  // Beat mux: word presented for a given beat index of a dwell report.
  function automatic logic [31:0] esm_dwell_report_word(
    input logic [3:0]        idx,
    input logic [31:0]       report_seq,
    input esm_dwell_report_t rpt
  );
    logic [31:0] word;
    word = '0;
    case (idx)
      4'd0:    word = esm_report_magic_num;
      4'd1:    word = report_seq;
      4'd2:    word = {esm_module_id_dwell_controller,
                       esm_report_message_type_dwell_stats, 16'h0000};
      4'd3:    word = rpt.dwell_sequence_num;
      4'd4:    word = {rpt.frequency, rpt.tag};
      4'd5:    word = rpt.duration;
      4'd6:    word = rpt.active_cycles;
      4'd7:    word = rpt.start_timestamp[31:0];
      4'd8:    word = rpt.start_timestamp[63:32];
      4'd9:    word = {rpt.gain, rpt.fast_lock_profile, rpt.drop_count};
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/esm_dwell_reporter.sv
// Dwell status reporter: at the end of every dwell, emits one fixed 10-word
// report on an AXI-stream master. Dwell ends that arrive while a report is
// still in flight are counted and reported in the next report's drop field.
module esm_dwell_reporter
  import esm_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Enable,
  input  logic                      Dwell_active,
  input  esm_dwell_metadata_t       Dwell_data,
  input  logic [31:0]               Dwell_sequence_num,
  input  logic [63:0]               Timestamp,
  input  logic                      Axis_ready,
  output logic                      Axis_valid,
  output logic [AXI_DATA_WIDTH-1:0] Axis_data,
  output logic                      Axis_last
);

  localparam int         REPORT_NUM_WORDS = esm_dwell_report_num_words;
  localparam logic [3:0] LAST_BEAT        = 4'(REPORT_NUM_WORDS - 1);

  // The beat mux produces 32-bit words; other widths are not supported.
  if (AXI_DATA_WIDTH != 32) begin : g_width_check
    $error("esm_dwell_reporter: AXI_DATA_WIDTH must be 32");
  end

  // Dwell edge tracking and start-of-dwell snapshot
  logic                r_active_reg;
  logic [31:0]         active_cycles_reg;
  esm_dwell_metadata_t snap_data_reg;
  logic [31:0]         snap_seq_reg;
  logic [63:0]         snap_ts_reg;

  // Report FSM state and registered AXI-stream outputs
  esm_report_state_t   state_reg;
  logic [3:0]          beat_reg;
  logic [31:0]         report_seq_reg;
  logic [15:0]         drop_count_reg;
  esm_dwell_report_t   report_reg;
  logic                axis_valid_reg;
  logic [31:0]         axis_data_reg;
  logic                axis_last_reg;

  logic                dwell_start;
  logic                dwell_end;
  logic                beat_fire;
  logic                capture;
  logic                drop;
  logic [3:0]          beat_next;

  assign dwell_start = Dwell_active && !r_active_reg;
  assign dwell_end   = !Dwell_active && r_active_reg;
  assign beat_fire   = axis_valid_reg && Axis_ready;
  assign capture     = dwell_end && Enable && (state_reg == S_IDLE);
  // A dwell ending while busy (including on the final handshake) is a drop.
  assign drop        = dwell_end && Enable && (state_reg != S_IDLE);
  assign beat_next   = beat_reg + 4'd1;

  // Register Dwell_active for edge detection and count cycles of the dwell
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_active_reg      <= 1'b0;
      active_cycles_reg <= '0;
    end else begin
      r_active_reg <= Dwell_active;
      if (dwell_start) begin
        active_cycles_reg <= 32'd1;
      end else if (Dwell_active && (active_cycles_reg != 32'hFFFF_FFFF)) begin
        active_cycles_reg <= active_cycles_reg + 32'd1;
      end
    end
  end

  // Snapshot dwell metadata, sequence number and timestamp on dwell start
  always_ff @(posedge Clk) begin
    if (Rst) begin
      snap_data_reg <= '0;
      snap_seq_reg  <= '0;
      snap_ts_reg   <= '0;
    end else if (dwell_start) begin
      snap_data_reg <= Dwell_data;
      snap_seq_reg  <= Dwell_sequence_num;
      snap_ts_reg   <= Timestamp;
    end
  end

  // Report FSM: capture on dwell end, then walk the beats on each handshake
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg      <= S_IDLE;
      beat_reg       <= '0;
      report_seq_reg <= '0;
      drop_count_reg <= '0;
      report_reg     <= '0;
      axis_valid_reg <= 1'b0;
      axis_data_reg  <= '0;
      axis_last_reg  <= 1'b0;
    end else begin
      // Drops only occur outside S_IDLE, so this never collides with the
      // clear performed on capture below.
      if (drop && (drop_count_reg != 16'hFFFF)) begin
        drop_count_reg <= drop_count_reg + 16'd1;
      end

      case (state_reg)
        S_IDLE: begin
          if (capture) begin
            report_reg.dwell_sequence_num <= snap_seq_reg;
            report_reg.frequency          <= snap_data_reg.frequency;
            report_reg.tag                <= snap_data_reg.tag;
            report_reg.duration           <= snap_data_reg.duration;
            report_reg.active_cycles      <= active_cycles_reg;
            report_reg.start_timestamp    <= snap_ts_reg;
            report_reg.gain               <= snap_data_reg.gain;
            report_reg.fast_lock_profile  <= snap_data_reg.fast_lock_profile;
            report_reg.drop_count         <= drop_count_reg;
            drop_count_reg                <= '0;
            state_reg                     <= S_SEND;
            beat_reg                      <= '0;
            axis_valid_reg                <= 1'b1;
            axis_data_reg                 <= esm_report_magic_num;
            axis_last_reg                 <= 1'b0;
          end
        end

        S_SEND: begin
          if (beat_fire) begin
            if (beat_reg == LAST_BEAT) begin
              state_reg      <= S_IDLE;
              beat_reg       <= '0;
              axis_valid_reg <= 1'b0;
              axis_data_reg  <= '0;
              axis_last_reg  <= 1'b0;
              report_seq_reg <= report_seq_reg + 32'd1;
            end else begin
              // report_reg was loaded at capture, so it is stable by beat 1.
              beat_reg      <= beat_next;
              axis_data_reg <= esm_dwell_report_word(beat_next, report_seq_reg, report_reg);
              axis_last_reg <= (beat_next == LAST_BEAT);
            end
          end
        end

        default: begin
          state_reg      <= S_IDLE;
          axis_valid_reg <= 1'b0;
          axis_last_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Axis_valid = axis_valid_reg;
  assign Axis_data  = axis_data_reg;
  assign Axis_last  = axis_last_reg;

endmodule

// File: tb/tb_esm_dwell_reporter.sv
// Testbench for esm_dwell_reporter: directed table of dwell scenarios,
// hand-written drop / reset / back-to-back sequences, and randomized dwells
// checked every cycle against an event-level reference model.
module tb_esm_dwell_reporter;
  import esm_pkg::*;

  typedef logic [9:0][31:0] rpt_t;

  logic                Clk = 1'b0;
  logic                Rst;
  logic                Enable;
  logic                Dwell_active;
  esm_dwell_metadata_t Dwell_data;
  logic [31:0]         Dwell_sequence_num;
  logic [63:0]         Timestamp;
  logic                Axis_ready;
  logic                Axis_valid;
  logic [31:0]         Axis_data;
  logic                Axis_last;

  esm_dwell_reporter #(.AXI_DATA_WIDTH(32)) dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .Enable             (Enable),
    .Dwell_active       (Dwell_active),
    .Dwell_data         (Dwell_data),
    .Dwell_sequence_num (Dwell_sequence_num),
    .Timestamp          (Timestamp),
    .Axis_ready         (Axis_ready),
    .Axis_valid         (Axis_valid),
    .Axis_data          (Axis_data),
    .Axis_last          (Axis_last)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int ready_mode = 1;  // 0 low, 1 high, 2 random 50%, 3 mostly low

  rpt_t got_q[$];
  rpt_t cur_rpt;
  int   cur_n = 0;

  // Reference model state
  logic                m_prev = 1'b0;
  logic [31:0]         m_cycles = '0;
  esm_dwell_metadata_t m_snap_meta = '0;
  logic [31:0]         m_snap_seq = '0;
  logic [63:0]         m_snap_ts = '0;
  logic                m_valid = 1'b0;
  int                  m_idx = 0;
  logic [31:0]         m_seq = '0;
  int                  m_drop = 0;
  rpt_t                m_words = '0;
  logic                m_st, m_end, m_hs, m_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic esm_dwell_metadata_t mk_meta(input logic [15:0] tag, input logic [15:0] freq,
                                                  input logic [31:0] dur, input logic [7:0] gain,
                                                  input logic [7:0] flp);
    esm_dwell_metadata_t m;
    m.tag = tag;
    m.frequency = freq;
    m.duration = dur;
    m.gain = gain;
    m.fast_lock_profile = flp;
    return m;
  endfunction

  // Downstream ready generator
  initial begin
    Axis_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      case (ready_mode)
        0:       Axis_ready = 1'b0;
        1:       Axis_ready = 1'b1;
        2:       Axis_ready = ($urandom % 2) == 0;
        default: Axis_ready = ($urandom % 4) == 0;
      endcase
    end
  end

  // Free-running timestamp, starting near a 32-bit rollover
  initial begin
    Timestamp = 64'h0000_0001_FFFF_FF00;
    forever begin
      @(posedge Clk);
      #1;
      Timestamp = Timestamp + 64'd1;
    end
  end

  // Reference model: tracks dwell events and what the link should be showing
  initial begin
    forever begin
      @(posedge Clk);
      if (Rst) begin
        m_prev = 1'b0; m_cycles = '0; m_valid = 1'b0; m_idx = 0;
        m_seq = '0; m_drop = 0; m_snap_meta = '0; m_snap_seq = '0; m_snap_ts = '0;
      end else begin
        m_st   = Dwell_active && !m_prev;
        m_end  = !Dwell_active && m_prev;
        m_hs   = m_valid && Axis_ready;
        m_busy = m_valid;
        if (m_st) begin
          m_cycles = 32'd1;
          m_snap_meta = Dwell_data;
          m_snap_seq = Dwell_sequence_num;
          m_snap_ts = Timestamp;
        end else if (Dwell_active && m_cycles != 32'hFFFF_FFFF) begin
          m_cycles = m_cycles + 32'd1;
        end
        if (m_hs) begin
          if (m_idx == 9) begin
            m_valid = 1'b0;
            m_idx = 0;
            m_seq = m_seq + 32'd1;
          end else begin
            m_idx = m_idx + 1;
          end
        end
        if (m_end && Enable) begin
          if (!m_busy) begin
            m_words[0] = esm_report_magic_num;
            m_words[1] = m_seq;
            m_words[2] = {esm_module_id_dwell_controller, esm_report_message_type_dwell_stats, 16'h0000};
            m_words[3] = m_snap_seq;
            m_words[4] = {m_snap_meta.frequency, m_snap_meta.tag};
            m_words[5] = m_snap_meta.duration;
            m_words[6] = m_cycles;
            m_words[7] = m_snap_ts[31:0];
            m_words[8] = m_snap_ts[63:32];
            m_words[9] = {m_snap_meta.gain, m_snap_meta.fast_lock_profile, 16'(m_drop)};
            m_drop = 0;
            m_valid = 1'b1;
            m_idx = 0;
          end else if (m_drop < 65535) begin
            m_drop = m_drop + 1;
          end
        end
        m_prev = Dwell_active;
      end
    end
  end

  // Per-cycle comparison against the model, plus collection of whole reports
  initial begin
    forever begin
      @(negedge Clk);
      check("axis_valid", Axis_valid, m_valid);
      if (m_valid) begin
        check($sformatf("beat%0d data", m_idx), Axis_data, m_words[m_idx]);
        check($sformatf("beat%0d last", m_idx), Axis_last, m_idx == 9);
      end
      if (Rst) begin
        cur_n = 0;
      end else if (Axis_valid && Axis_ready) begin
        if (cur_n < 10) cur_rpt[cur_n] = Axis_data;
        cur_n++;
        if (Axis_last) begin
          got_q.push_back(cur_rpt);
          cur_n = 0;
        end
      end
    end
  end

  task automatic run_dwell(input int len, input esm_dwell_metadata_t meta, input logic [31:0] seq,
                           input logic en_end, input int gap);
    tick();
    Dwell_active = 1'b1;
    Dwell_data = meta;
    Dwell_sequence_num = seq;
    repeat (len) tick();
    Dwell_active = 1'b0;
    Enable = en_end;
    Dwell_data = esm_dwell_metadata_t'({$urandom, $urandom, $urandom});
    Dwell_sequence_num = $urandom;
    tick();
    Enable = 1'b1;
    repeat (gap - 1) tick();
  endtask

  task automatic wait_reports(input int n, input int budget, input string name);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check(name, got_q.size(), n);
  endtask

  task automatic pulse_reset();
    Rst = 1'b1;
    repeat (2) tick();
    Rst = 1'b0;
  endtask

  typedef struct {
    int          len;
    logic        en;
    int          rmode;
    logic [15:0] tag;
    logic [15:0] freq;
    logic [31:0] seq;
    int          exp_n;
    logic [31:0] exp_w1;
    logic [31:0] exp_w6;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t tbl[4];
  rpt_t r;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got %0d expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    esm_dwell_metadata_t meta;
    int c;

    tbl[0] = '{50, 1'b1, 1, 16'h1234, 16'h0ABC, 32'd7,  1, 32'd0, 32'd50, 16'd0};
    tbl[1] = '{50, 1'b1, 2, 16'h1234, 16'h0ABC, 32'd7,  1, 32'd1, 32'd50, 16'd0};
    tbl[2] = '{20, 1'b0, 1, 16'hBEEF, 16'h0001, 32'd9,  0, 32'd0, 32'd0,  16'd0};
    tbl[3] = '{8,  1'b1, 1, 16'h00C3, 16'h1F00, 32'd10, 1, 32'd2, 32'd8,  16'd0};

    Rst = 1'b1;
    Enable = 1'b1;
    Dwell_active = 1'b0;
    Dwell_data = '0;
    Dwell_sequence_num = '0;
    repeat (3) tick();
    check("reset axis_valid", Axis_valid, 1'b0);
    check("reset axis_data", Axis_data, 32'h0);
    check("reset axis_last", Axis_last, 1'b0);
    Rst = 1'b0;
    repeat (2) tick();

    // Directed table of single dwells
    for (int i = 0; i < 4; i++) begin
      got_q.delete();
      ready_mode = tbl[i].rmode;
      meta = mk_meta(tbl[i].tag, tbl[i].freq, 32'd1000 + 32'(i), 8'h5A, 8'h03);
      run_dwell(tbl[i].len, meta, tbl[i].seq, tbl[i].en, 1);
      if (tbl[i].exp_n == 0) begin
        repeat (40) tick();
        check($sformatf("vec%0d no report", i), got_q.size(), 0);
      end else begin
        wait_reports(1, 300, $sformatf("vec%0d report count", i));
        if (got_q.size() > 0) begin
          r = got_q[0];
          check($sformatf("vec%0d w0", i), r[0], esm_report_magic_num);
          check($sformatf("vec%0d w1", i), r[1], tbl[i].exp_w1);
          check($sformatf("vec%0d w2", i), r[2], {esm_module_id_dwell_controller, esm_report_message_type_dwell_stats, 16'h0000});
          check($sformatf("vec%0d w3", i), r[3], tbl[i].seq);
          check($sformatf("vec%0d w4", i), r[4], {tbl[i].freq, tbl[i].tag});
          check($sformatf("vec%0d w5", i), r[5], 32'd1000 + 32'(i));
          check($sformatf("vec%0d w6", i), r[6], tbl[i].exp_w6);
          check($sformatf("vec%0d w9", i), r[9], {8'h5A, 8'h03, tbl[i].exp_drop});
        end
      end
      ready_mode = 1;
      repeat (5) tick();
    end

    // Drops while the link is stalled
    got_q.delete();
    ready_mode = 0;
    for (int k = 0; k < 3; k++) run_dwell(10, mk_meta(16'h0D00 + 16'(k), 16'h0100, 32'd5, 8'h11, 8'h22), 32'd100 + 32'(k), 1'b1, 20);
    repeat (110) tick();
    ready_mode = 1;
    wait_reports(1, 50, "drop stalled report");
    run_dwell(10, mk_meta(16'h0E00, 16'h0200, 32'd6, 8'h33, 8'h44), 32'd200, 1'b1, 15);
    wait_reports(2, 50, "drop second report");
    run_dwell(10, mk_meta(16'h0F00, 16'h0300, 32'd7, 8'h55, 8'h66), 32'd201, 1'b1, 15);
    wait_reports(3, 50, "drop third report");
    if (got_q.size() == 3) begin
      r = got_q[0]; check("drop rpt0 w3", r[3], 32'd100); check("drop rpt0 count", r[9][15:0], 16'd0);
      r = got_q[1]; check("drop rpt1 w3", r[3], 32'd200); check("drop rpt1 count", r[9][15:0], 16'd2);
      r = got_q[2]; check("drop rpt2 count", r[9][15:0], 16'd0);
    end

    // Reset while beat w4 is presented
    got_q.delete();
    run_dwell(12, mk_meta(16'h4444, 16'h5555, 32'd9, 8'h01, 8'h02), 32'd300, 1'b1, 1);
    c = 0;
    while (!Axis_valid && c < 20) begin tick(); c++; end
    check("rst test valid up", Axis_valid, 1'b1);
    repeat (4) tick();
    check("rst test beat4 data", Axis_data, 32'h5555_4444);
    Rst = 1'b1;
    tick();
    check("rst mid valid", Axis_valid, 1'b0);
    check("rst mid data", Axis_data, 32'h0);
    check("rst mid last", Axis_last, 1'b0);
    Rst = 1'b0;
    tick();
    run_dwell(6, mk_meta(16'h6666, 16'h7777, 32'd9, 8'h01, 8'h02), 32'd301, 1'b1, 1);
    wait_reports(1, 50, "post reset report");
    if (got_q.size() == 1) begin
      r = got_q[0];
      check("post reset w1", r[1], 32'd0);
      check("post reset w3", r[3], 32'd301);
    end

    // 1-cycle dwell then five back-to-back dwells
    pulse_reset();
    got_q.delete();
    run_dwell(1, mk_meta(16'hA000, 16'hB000, 32'd1, 8'h0F, 8'hF0), 32'd500, 1'b1, 12);
    for (int k = 0; k < 5; k++) run_dwell(3, mk_meta(16'hA001 + 16'(k), 16'hB000, 32'd2, 8'h0F, 8'hF0), 32'd501 + 32'(k), 1'b1, 12);
    wait_reports(6, 100, "b2b report count");
    if (got_q.size() == 6) begin
      r = got_q[0];
      check("b2b first w6", r[6], 32'd1);
      for (int k = 0; k < 6; k++) begin
        r = got_q[k];
        check($sformatf("b2b rpt%0d w1", k), r[1], 32'(k));
        check($sformatf("b2b rpt%0d drop", k), r[9][15:0], 16'd0);
      end
    end

    // Randomized dwells against the reference model
    for (int k = 0; k < 60; k++) begin
      ready_mode = $urandom_range(3, 1);
      meta = esm_dwell_metadata_t'({$urandom, $urandom, $urandom});
      run_dwell($urandom_range(25, 1), meta, $urandom, ($urandom % 8) != 0, $urandom_range(20, 1));
    end
    ready_mode = 1;
    repeat (40) tick();
    check("final idle valid", Axis_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
